// File: rtl/key_pkg.sv
// Shared types and constants for the per-key gesture decoder.
package key_pkg;

  // Gesture-tracking states of the key event decoder.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRESS1 = 3'd1,
    ST_WAIT2  = 3'd2,
    ST_PRESS2 = 3'd3,
    ST_HOLD   = 3'd4
  } key_state_e;

  // Debounced key levels: the button pulls the line low when pressed.
  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  // Default timing, derived from the 50 MHz system clock.
  localparam int CLK_HZ         = 50_000_000;
  localparam int LONG_CNT_DEF   = CLK_HZ;            // 1 s hold
  localparam int REPEAT_CNT_DEF = CLK_HZ / 5;        // 200 ms repeat period
  localparam int DCLICK_CNT_DEF = (CLK_HZ / 10) * 3; // 300 ms double-click window
  localparam int CNT_W_DEF      = 26;

endpackage

// File: rtl/key_event_decoder.sv
// Turns the debounced level/strobe of one push-button into one-cycle gesture
// pulses: short press, double click, long press and auto-repeat while held.
module key_event_decoder
  import key_pkg::*;
#(
  parameter int LONG_CNT   = LONG_CNT_DEF,
  parameter int REPEAT_CNT = REPEAT_CNT_DEF,
  parameter int DCLICK_CNT = DCLICK_CNT_DEF,
  parameter bit DCLICK_EN  = 1'b1,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_value,
  input  logic key_flag,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_press,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 1);

  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             short_q, short_d;
  logic             dclick_q, dclick_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             busy_q, busy_d;

  logic press_ev;
  logic release_ev;

  // Key events exist only on the strobe; the level is ignored otherwise.
  assign press_ev   = key_flag && (key_value == KEY_PRESSED);
  assign release_ev = key_flag && (key_value == KEY_RELEASED);

  // Next state, shared timer and pulse outputs; key events win over timeouts.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q + 1'b1;
    short_d  = 1'b0;
    dclick_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (press_ev) begin
          state_d = ST_PRESS1;
        end
      end

      ST_PRESS1: begin
        if (release_ev) begin
          timer_d = '0;
          if (DCLICK_EN) begin
            state_d = ST_WAIT2;
          end else begin
            state_d = ST_IDLE;
            short_d = 1'b1;
          end
        end else if (timer_q == LONG_LAST) begin
          timer_d = '0;
          state_d = ST_HOLD;
          long_d  = 1'b1;
        end
      end

      ST_WAIT2: begin
        if (press_ev) begin
          timer_d = '0;
          state_d = ST_PRESS2;
        end else if (timer_q == DCLICK_LAST) begin
          timer_d = '0;
          state_d = ST_IDLE;
          short_d = 1'b1;
        end
      end

      ST_PRESS2: begin
        if (release_ev) begin
          timer_d  = '0;
          state_d  = ST_IDLE;
          dclick_d = 1'b1;
        end else if (timer_q == LONG_LAST) begin
          // The first click is reported late, together with the long hold.
          timer_d = '0;
          state_d = ST_HOLD;
          short_d = 1'b1;
          long_d  = 1'b1;
        end
      end

      ST_HOLD: begin
        if (release_ev) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (timer_q == REPEAT_LAST) begin
          timer_d  = '0;
          repeat_d = 1'b1;
        end
      end

      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, timer and registered outputs; reset discards any gesture in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      short_q  <= 1'b0;
      dclick_q <= 1'b0;
      long_q   <= 1'b0;
      repeat_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      short_q  <= short_d;
      dclick_q <= dclick_d;
      long_q   <= long_d;
      repeat_q <= repeat_d;
      busy_q   <= busy_d;
    end
  end

  assign short_press  = short_q;
  assign double_click = dclick_q;
  assign long_press   = long_q;
  assign repeat_press = repeat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: two instances (double-click enabled/disabled)
// share one stimulus; a timestamp-based gesture model is compared every cycle,
// and literal pulse timings pin each directed scenario.
module tb_key_event_decoder;

  localparam int L = 20;
  localparam int R = 5;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_value = 1'b1;
  logic key_flag = 1'b0;

  logic [1:0] sp, dc, lp, rp, by;

  // Index 0: double-click detection on; index 1: off.
  key_event_decoder #(
    .LONG_CNT(L), .REPEAT_CNT(R), .DCLICK_CNT(D), .DCLICK_EN(1'b1), .CNT_W(8)
  ) dut_en (
    .clk(clk), .rst_n(rst_n), .key_value(key_value), .key_flag(key_flag),
    .short_press(sp[0]), .double_click(dc[0]), .long_press(lp[0]),
    .repeat_press(rp[0]), .busy(by[0])
  );

  key_event_decoder #(
    .LONG_CNT(L), .REPEAT_CNT(R), .DCLICK_CNT(D), .DCLICK_EN(1'b0), .CNT_W(8)
  ) dut_nd (
    .clk(clk), .rst_n(rst_n), .key_value(key_value), .key_flag(key_flag),
    .short_press(sp[1]), .double_click(dc[1]), .long_press(lp[1]),
    .repeat_press(rp[1]), .busy(by[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int base = 0;

  // Model state: gesture described by click count and edge timestamps.
  int m_clicks[2];
  bit m_down[2];
  bit m_long[2];
  int t_press[2];
  int t_rel[2];
  int t_anchor[2];
  bit e_sp[2], e_dc[2], e_lp[2], e_rp[2];

  // Per-test log of what the DUTs actually pulsed (edge numbers relative to base).
  int n_sp[2], n_dc[2], n_lp[2], n_rp[2];
  int at_sp[2], at_dc[2], at_lp[2], first_rp[2], last_rp[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_step(input int k, input bit pr, input bit rl, input int n);
    e_sp[k] = 1'b0; e_dc[k] = 1'b0; e_lp[k] = 1'b0; e_rp[k] = 1'b0;
    if (m_clicks[k] == 0) begin
      if (pr) begin
        m_clicks[k] = 1; m_down[k] = 1'b1; m_long[k] = 1'b0; t_press[k] = n;
      end
    end else if (m_long[k]) begin
      if (rl) m_clicks[k] = 0;
      else if (n - t_anchor[k] == R) begin
        e_rp[k] = 1'b1; t_anchor[k] = n;
      end
    end else if (m_down[k]) begin
      if (rl) begin
        if (m_clicks[k] == 2) begin
          e_dc[k] = 1'b1; m_clicks[k] = 0;
        end else if (k == 0) begin
          m_down[k] = 1'b0; t_rel[k] = n;
        end else begin
          e_sp[k] = 1'b1; m_clicks[k] = 0;
        end
      end else if (n - t_press[k] == L) begin
        e_lp[k] = 1'b1; e_sp[k] = (m_clicks[k] == 2); m_long[k] = 1'b1; t_anchor[k] = n;
      end
    end else begin
      if (pr) begin
        m_clicks[k] = 2; m_down[k] = 1'b1; t_press[k] = n;
      end else if (n - t_rel[k] == D) begin
        e_sp[k] = 1'b1; m_clicks[k] = 0;
      end
    end
  endtask

  // Compare process: advance the model on each edge, check the DUTs 1 ns later.
  initial begin
    for (int k = 0; k < 2; k++) m_clicks[k] = 0;
    forever begin
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          m_clicks[k] = 0;
          e_sp[k] = 1'b0; e_dc[k] = 1'b0; e_lp[k] = 1'b0; e_rp[k] = 1'b0;
        end else begin
          model_step(k, key_flag && !key_value, key_flag && key_value, cyc);
        end
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        check($sformatf("short[%0d]@%0d", k, cyc - base), int'(sp[k]), int'(e_sp[k]));
        check($sformatf("dclick[%0d]@%0d", k, cyc - base), int'(dc[k]), int'(e_dc[k]));
        check($sformatf("long[%0d]@%0d", k, cyc - base), int'(lp[k]), int'(e_lp[k]));
        check($sformatf("repeat[%0d]@%0d", k, cyc - base), int'(rp[k]), int'(e_rp[k]));
        check($sformatf("busy[%0d]@%0d", k, cyc - base), int'(by[k]), int'(m_clicks[k] != 0));
        if (sp[k]) begin n_sp[k]++; at_sp[k] = cyc - base; end
        if (dc[k]) begin n_dc[k]++; at_dc[k] = cyc - base; end
        if (lp[k]) begin n_lp[k]++; at_lp[k] = cyc - base; end
        if (rp[k]) begin
          if (n_rp[k] == 0) first_rp[k] = cyc - base;
          n_rp[k]++; last_rp[k] = cyc - base;
        end
      end
    end
  end

  task automatic clear_log();
    for (int k = 0; k < 2; k++) begin
      n_sp[k] = 0; n_dc[k] = 0; n_lp[k] = 0; n_rp[k] = 0;
      at_sp[k] = -1; at_dc[k] = -1; at_lp[k] = -1; first_rp[k] = -1; last_rp[k] = -1;
    end
  endtask

  // Begin a scenario: the next rising edge becomes relative edge 0.
  task automatic start_test();
    @(negedge clk);
    base = cyc + 1;
    clear_log();
  endtask

  // Park on the negedge just before relative edge e.
  task automatic run_to(input int e);
    while (cyc + 1 < base + e) @(negedge clk);
  endtask

  // Present a key event sampled on relative edge e.
  task automatic ev(input int e, input bit v);
    run_to(e);
    key_flag = 1'b1;
    key_value = v;
    @(negedge clk);
    key_flag = 1'b0;
    key_value = 1'($urandom_range(0, 1));
  endtask

  initial begin
    clear_log();
    repeat (3) @(negedge clk);
    check("reset_short", int'(sp[0]), 0);
    check("reset_busy", int'(by[0]), 0);
    check("reset_all_nd", int'({sp[1], dc[1], lp[1], rp[1], by[1]}), 0);
    rst_n = 1'b1;

    // Single click.
    start_test();
    ev(0, 1'b0); ev(5, 1'b1); run_to(25);
    $display("single click: en short=%0d@%0d, nd short=%0d@%0d", n_sp[0], at_sp[0], n_sp[1], at_sp[1]);
    check("t1_short_cnt", n_sp[0], 1);
    check("t1_short_edge", at_sp[0], 13);
    check("t1_others", n_dc[0] + n_lp[0] + n_rp[0], 0);
    check("t1_nd_short_edge", at_sp[1], 5);
    check("t1_busy_end", int'(by[0]), 0);

    // Double click.
    start_test();
    ev(0, 1'b0); ev(4, 1'b1); ev(7, 1'b0); ev(10, 1'b1); run_to(30);
    $display("double click: en dclick=%0d@%0d short=%0d, nd short=%0d", n_dc[0], at_dc[0], n_sp[0], n_sp[1]);
    check("t2_dclick_cnt", n_dc[0], 1);
    check("t2_dclick_edge", at_dc[0], 10);
    check("t2_no_short", n_sp[0], 0);
    check("t2_nd_two_shorts", n_sp[1], 2);

    // Long hold with auto-repeat.
    start_test();
    ev(0, 1'b0); ev(41, 1'b1); run_to(55);
    $display("long hold: long@%0d repeats=%0d first@%0d last@%0d", at_lp[0], n_rp[0], first_rp[0], last_rp[0]);
    check("t3_long_edge", at_lp[0], 20);
    check("t3_repeat_cnt", n_rp[0], 4);
    check("t3_first_repeat", first_rp[0], 25);
    check("t3_last_repeat", last_rp[0], 40);
    check("t3_no_short", n_sp[0] + n_dc[0], 0);

    // Click then press-and-hold.
    start_test();
    ev(0, 1'b0); ev(3, 1'b1); ev(6, 1'b0); ev(33, 1'b1); run_to(45);
    $display("click+hold: short@%0d long@%0d first repeat@%0d", at_sp[0], at_lp[0], first_rp[0]);
    check("t4_short_edge", at_sp[0], 26);
    check("t4_long_edge", at_lp[0], 26);
    check("t4_first_repeat", first_rp[0], 31);
    check("t4_repeat_cnt", n_rp[0], 1);

    // Release on the same edge the long count expires.
    start_test();
    ev(0, 1'b0); ev(20, 1'b1); run_to(40);
    $display("release vs long: long=%0d short@%0d, nd short@%0d", n_lp[0], at_sp[0], at_sp[1]);
    check("t5_no_long", n_lp[0] + n_lp[1], 0);
    check("t5_short_edge", at_sp[0], 28);
    check("t5_nd_short_edge", at_sp[1], 20);

    // Reset while holding, right while a repeat pulse is high.
    start_test();
    ev(0, 1'b0); run_to(26);
    check("t6_repeat_before_reset", int'(rp[0]), 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_clear", int'({sp, dc, lp, rp, by}), 0);
    clear_log();
    ev(28, 1'b1);
    rst_n = 1'b1;
    run_to(50);
    $display("reset mid-hold: pulses after reset en=%0d nd=%0d",
             n_sp[0] + n_dc[0] + n_lp[0] + n_rp[0], n_sp[1] + n_dc[1] + n_lp[1] + n_rp[1]);
    check("t6_no_pulses", n_sp[0] + n_dc[0] + n_lp[0] + n_rp[0] + n_sp[1] + n_dc[1] + n_lp[1] + n_rp[1], 0);
    check("t6_idle", int'(by), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
Name: key_event_decoder

Overview:
- Consumes the debounced key outputs (key_value level, key_flag one-cycle strobe) of one push-button.
- Classifies each gesture into one-cycle event pulses: short press, double click, long press and auto-repeat while held.
- Sits between the per-key debouncer and the clock's time-setting control logic; one instance per key.

Parameters:
- LONG_CNT, 50_000_000, hold duration in clk cycles before long_press fires (1 s at 50 MHz).
- REPEAT_CNT, 10_000_000, period in clk cycles of repeat_press while held after long_press (200 ms).
- DCLICK_CNT, 15_000_000, window in clk cycles after first release to accept a second press (300 ms).
- DCLICK_EN, 1, 1 = double-click detection enabled; 0 = short_press issued on release with no window.
- CNT_W, 26, timer width; must satisfy 2^CNT_W > max(LONG_CNT, REPEAT_CNT, DCLICK_CNT).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_value  input  1  debounced key level; 0 = pressed, 1 = released; valid when key_flag = 1.
- key_flag  input  1  one-cycle strobe; key_value just became stable.
- short_press  output  1  one-cycle pulse: single click.
- double_click  output  1  one-cycle pulse: two clicks within the window.
- long_press  output  1  one-cycle pulse: hold reached LONG_CNT.
- repeat_press  output  1  one-cycle pulse every REPEAT_CNT cycles while held after long_press.
- busy  output  1  level; 1 when FSM is not in IDLE.

Behaviour:
- Reset: rst_n is asynchronous and active-low; clock is clk. On reset, FSM goes to IDLE, timer = 0, and all outputs = 0. Reset mid-gesture discards the gesture with no pulse.
- Press event: key_flag=1 and key_value=0. Release event: key_flag=1 and key_value=1. key_flag=0 means no event; key_value is ignored.
- Redundant events are ignored: a press while pressed, or a release in IDLE/WAIT2.
- Timer: reset to 0 on every state transition. Otherwise it increments by 1 each cycle in PRESS1, WAIT2, PRESS2 and HOLD, and holds 0 in IDLE.
- All outputs are registered. A pulse is high for exactly the one cycle after the edge that takes the transition.
- States:
  - IDLE: press -> PRESS1.
  - PRESS1: release with DCLICK_EN=1 -> WAIT2. Release with DCLICK_EN=0 -> IDLE, pulse short_press. Timer==LONG_CNT-1 -> HOLD, pulse long_press.
  - WAIT2: press -> PRESS2. Timer==DCLICK_CNT-1 -> IDLE, pulse short_press.
  - PRESS2: release -> IDLE, pulse double_click. Timer==LONG_CNT-1 -> HOLD, pulse short_press and long_press in the same cycle.
  - HOLD: timer==REPEAT_CNT-1 -> pulse repeat_press and reset timer, staying in HOLD. Release -> IDLE, no pulse.
- Simultaneous events (an event strobe on the same edge the timer reaches its terminal count): the key event wins.
  - PRESS1/PRESS2: release wins over long.
  - WAIT2: press wins over timeout.
  - HOLD: release wins; no repeat pulse is issued.
- Latency: long_press rises LONG_CNT edges after the edge sampling the press event. The first repeat_press follows long_press by REPEAT_CNT edges.
- At most one of short_press, double_click or repeat_press is high per cycle. long_press coincides only with short_press, via PRESS2.
- busy = (state != IDLE), registered with the state.

Decomposition:
- Shared package key_pkg holds:
  - state enum (IDLE, PRESS1, WAIT2, PRESS2, HOLD);
  - KEY_PRESSED=1'b0 and KEY_RELEASED=1'b1 constants;
  - default timing constants derived from CLK_HZ=50_000_000.
- No sub-module: the FSM and single shared timer stay in one module.
- Top level instantiates the debouncer followed by key_event_decoder per key.

Test Plan (LONG_CNT=20, REPEAT_CNT=5, DCLICK_CNT=8, DCLICK_EN=1):
- Press at edge 0, release at edge 5, no further event -> short_press pulses once, 8 edges after the release edge. No other pulses. busy returns to 0.
- Press at 0, release at 4, press at 7, release at 10 -> single double_click pulse after edge 10. No short_press.
- Press at 0, held through edge 40, release at 41:
  - long_press after edge 20;
  - repeat_press after edges 25, 30, 35, 40;
  - nothing on release.
- Press at 0, release at 3, press at 6, held -> short_press and long_press together after edge 26, then repeat after edge 31.
- Release strobe on the same edge PRESS1 timer hits 19 -> WAIT2 entered, no long_press. Then short_press after timeout.
- Assert rst_n=0 mid-HOLD, and also with DCLICK_EN=0 do press 0 / release 5 -> reset case: all outputs 0 immediately, no pulses after release. DCLICK_EN=0 case: short_press after edge 5.
